// File: rtl/trace_checker_pkg.sv
// Shared state encoding and PC constants for the commit-stream trace checker.
package trace_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  localparam logic [31:0] PC_START   = 32'h0;
  localparam int          WORD_SHIFT = 2;

endpackage

// File: rtl/trace_checker_if.sv
// Table-load, core-sample and status bundle between a host and trace_checker.
interface trace_checker_if #(
  parameter int ADDR_W = 4,
  parameter int ERR_W  = 8,
  parameter int CYC_W  = 8
);
  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_idx;
  logic [31:0]       tbl_data;
  logic [31:0]       tbl_mask;
  logic              start;
  logic [31:0]       pc;
  logic [31:0]       aluout;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [ERR_W-1:0]  err_cnt;
  logic [31:0]       first_err_pc;
  logic [CYC_W-1:0]  cycle_cnt;

  modport master (
    output tbl_we, tbl_idx, tbl_data, tbl_mask, start, pc, aluout,
    input  busy, done, pass, timeout, err_cnt, first_err_pc, cycle_cnt
  );

  modport slave (
    input  tbl_we, tbl_idx, tbl_data, tbl_mask, start, pc, aluout,
    output busy, done, pass, timeout, err_cnt, first_err_pc, cycle_cnt
  );
endinterface

// File: rtl/trace_exp_table.sv
// Expected-result table with valid/hit tracking; mask storage only when
// TRACE_CHECK_MASK_EN is defined.
module trace_exp_table #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef TRACE_CHECK_MASK_EN
  input  logic [31:0]       wmask,
  output logic [31:0]       rmask,
`endif
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [31:0]       wdata,
  input  logic              clr_hit,
  input  logic              set_hit,
  input  logic [ADDR_W-1:0] ridx,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              all_hit
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] hit_q;

  // Contents are don't-care after reset, so the arrays carry no reset.
  always_ff @(posedge clk)
    if (we) data_q[widx] <= wdata;

`ifdef TRACE_CHECK_MASK_EN
  logic [31:0] mask_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mask_q[widx] <= wmask;
  assign rmask = mask_q[ridx];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      hit_q   <= '0;
    end else begin
      if (we) valid_q[widx] <= 1'b1;
      if (clr_hit)      hit_q       <= '0;
      else if (set_hit) hit_q[ridx] <= 1'b1;
    end
  end

  assign rdata   = data_q[ridx];
  assign rvalid  = valid_q[ridx];
  // Entries never loaded count as already hit, so an empty table is complete.
  assign all_hit = &(hit_q | ~valid_q);
endmodule

// File: rtl/trace_checker.sv
// Compares the core's (pc, aluout) commit stream against a loaded table.
// Define TRACE_CHECK_MASK_EN for per-entry bit masks on the compare.
module trace_checker
  import trace_chk_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int ERR_W   = 8,
  parameter int CYC_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  trace_checker_if.slave  bus
);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] ridx;
  logic [31:0]       rdata;
  logic              rvalid, all_hit;
  logic              aligned, in_range, eligible, mismatch;
  logic              cmp_en, err_hit, hit_set, restart, tbl_wr;
  logic [ERR_W-1:0]  err_next;

  assign ridx     = bus.pc[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
  assign aligned  = bus.pc[WORD_SHIFT-1:0] == '0;
  assign in_range = (bus.pc >> (ADDR_W + WORD_SHIFT)) == 32'd0;
  assign eligible = aligned && in_range && rvalid;

`ifdef TRACE_CHECK_MASK_EN
  logic [31:0] rmask;
  assign mismatch = ((bus.aluout ^ rdata) & rmask) != 32'd0;
`else
  assign mismatch = bus.aluout != rdata;
`endif

  // The ARMED edge that first sees PC_START is also the first compare.
  assign cmp_en   = (state == ST_RUN) || (state == ST_ARMED && bus.pc == PC_START);
  assign err_hit  = cmp_en && (eligible ? mismatch : !aligned);
  assign hit_set  = cmp_en && eligible;
  assign err_next = (err_hit && err_cnt_sat_n()) ? bus.err_cnt + 1'b1 : bus.err_cnt;
  assign restart  = bus.start && (state == ST_IDLE || state == ST_PASS || state == ST_FAIL);
  assign tbl_wr   = bus.tbl_we && (state == ST_IDLE);

  function automatic logic err_cnt_sat_n();
    return bus.err_cnt != '1;
  endfunction

  trace_exp_table #(.ADDR_W(ADDR_W)) u_tbl (
    .clk     (clk),
    .reset   (reset),
`ifdef TRACE_CHECK_MASK_EN
    .wmask   (bus.tbl_mask),
    .rmask   (rmask),
`endif
    .we      (tbl_wr),
    .widx    (bus.tbl_idx),
    .wdata   (bus.tbl_data),
    .clr_hit (restart),
    .set_hit (hit_set),
    .ridx    (ridx),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .all_hit (all_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.pass         <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.err_cnt      <= '0;
      bus.first_err_pc <= '0;
      bus.cycle_cnt    <= '0;
    end else begin
      if (cmp_en) begin
        bus.err_cnt <= err_next;
        if (err_hit && bus.err_cnt == '0) bus.first_err_pc <= bus.pc;
      end
      case (state)
        ST_IDLE, ST_PASS, ST_FAIL: if (restart) begin
          state            <= ST_ARMED;
          bus.busy         <= 1'b1;
          bus.done         <= 1'b0;
          bus.pass         <= 1'b0;
          bus.timeout      <= 1'b0;
          bus.err_cnt      <= '0;
          bus.first_err_pc <= '0;
          bus.cycle_cnt    <= '0;
        end
        ST_ARMED: if (bus.pc == PC_START) state <= ST_RUN;
        ST_RUN: begin
          // Decide on err_next so an error on the completing edge still fails.
          if (all_hit) begin
            state    <= (err_next == '0) ? ST_PASS : ST_FAIL;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (err_next == '0);
          end else if (bus.cycle_cnt == CYC_LAST) begin
            state       <= ST_FAIL;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.timeout <= 1'b1;
          end else begin
            bus.cycle_cnt <= bus.cycle_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
Synthesizable receiver for the single-cycle core's commit stream (pc, aluout).
- Holds a loadable table of expected ALU results, indexed by word-aligned PC.
- Samples the core every clock and compares aluout against the table entry.
- Counts mismatches, records the first failing PC, and signals pass/fail/timeout.
- Sits beside `top` in FPGA self-test builds, replacing the simulation-only checker.

Parameters:
ADDR_W, 4, table index width; DEPTH = 2**ADDR_W entries covering PC 0x00 .. 4*DEPTH-4
ERR_W, 8, error counter width (saturating)
CYC_W, 8, cycle counter width
TIMEOUT, 64, RUN cycles allowed before forced FAIL; must satisfy 1 <= TIMEOUT < 2**CYC_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
tbl_we  in  1  table write strobe; honoured only in IDLE
tbl_idx  in  ADDR_W  table entry written
tbl_data  in  32  expected aluout for that entry
tbl_mask  in  32  per-bit compare mask (used only with macro; ignored otherwise)
start  in  1  one-cycle pulse that begins a check run
pc  in  32  core program counter
aluout  in  32  core ALU result
busy  out  1  high in ARMED or RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS only
timeout  out  1  high when FAIL was caused by TIMEOUT
err_cnt  out  ERR_W  mismatch count
first_err_pc  out  32  PC of the first mismatch; 0 if none
cycle_cnt  out  CYC_W  RUN cycles elapsed

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0; all valid and hit bits go to 0.
  - Table data is don't-care.
- Table writes: when tbl_we is high in IDLE, data[tbl_idx] <= tbl_data and valid[tbl_idx] <= 1 on that edge. tbl_we in any other state is ignored.
- State machine (states IDLE, ARMED, RUN, PASS, FAIL):
  - IDLE -> ARMED on start.
  - PASS/FAIL -> ARMED on start. Restart clears err_cnt, first_err_pc, cycle_cnt, timeout and all hit bits. Valid bits and table data are kept.
  - ARMED -> RUN on the first edge where pc == 0. That same edge is also the first compare cycle.
  - RUN -> PASS when every valid entry has its hit bit set and err_cnt == 0.
  - RUN -> FAIL when every valid entry has its hit bit set and err_cnt != 0.
  - RUN -> FAIL with timeout <= 1 when cycle_cnt reaches TIMEOUT-1 and the table is not fully hit.
  - start in ARMED or RUN is ignored.
- Compare (on every RUN edge, including the ARMED->RUN edge):
  - An entry is eligible when pc[1:0] == 0, pc < 4*DEPTH, and valid[pc[ADDR_W+1:2]] == 1.
  - Eligible entry: set its hit bit. If aluout != data, increment err_cnt.
  - Not eligible but pc[1:0] != 0: misaligned PC, increment err_cnt.
  - Otherwise: no check.
  - First error only: first_err_pc <= pc.
  - err_cnt saturates at 2**ERR_W-1.
- Revisits: an entry visited again (loop or branch) is re-checked every time; its hit bit stays set.
- Latency: the compare is combinational on that edge's inputs and registered. err_cnt reflects a mismatch 1 clock later. done rises 1 clock after the edge that sets the final hit bit.
- Completion priority: if the final hit and a mismatch occur on the same edge, that error is counted before the PASS/FAIL decision, so the result is FAIL.
- Empty table: no valid entries means the table is already "fully hit". ARMED->RUN is followed by PASS on the next edge with err_cnt = 0.
- cycle_cnt: increments in RUN only and holds in PASS/FAIL.

Optional Feature:
TRACE_CHECK_MASK_EN
- Defined: each entry also stores tbl_mask, written alongside tbl_data. A mismatch is ((aluout ^ data) & mask) != 0. A mask of 0 makes the entry a visit-only check.
- Undefined: no mask storage is built, tbl_mask is ignored, and the compare is full 32-bit equality.

Decomposition:
- Package trace_chk_pkg: state encoding (IDLE=0, ARMED=1, RUN=2, PASS=3, FAIL=4, 3-bit), and the constants PC_START=32'h0 and WORD_SHIFT=2.
- Sub-module trace_exp_table:
  - DEPTH x 32 data array, plus the mask array under the macro.
  - Valid and hit vectors.
  - Write port and combinational read at pc index.
  - Outputs all_hit = &(hit | ~valid).
- trace_checker keeps the FSM, counters and compare logic.

Test Plan:
- Load 0x00->0, 0x04->2, 0x08->4, 0x0C->1, 0x10->3, 0x14->2, 0x18->0, 0x1C->0, 0x20->0 and run the core program -> done=1, pass=1, err_cnt=0, timeout=0, cycle_cnt=8.
- Same table, drive aluout=5 at pc=0x08 -> done=1, pass=0, err_cnt=1, first_err_pc=0x08.
- Load 0x00..0x10 valid and drive a pc that stops at 0x0C (entry 0x10 never hit) -> after 64 RUN cycles done=1, pass=0, timeout=1.
- Drive pc=0x06 in RUN -> err_cnt increments by 1 and first_err_pc=0x06. Then assert reset mid-RUN -> all outputs 0 and state IDLE immediately, without waiting for a clock edge.
- With TRACE_CHECK_MASK_EN: entry 0x04 data=0x12 mask=0xF0, aluout=0x1F -> no error and pass=1. Without the macro, the same stimulus -> err_cnt=1.
- Restart from PASS with start, table untouched -> counters and hit bits cleared, and the second run also passes. tbl_we during RUN -> table unchanged.
